ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
PS/2 host-to-device transmitter. It sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset) to the keyboard over the same ps2_clock/ps2_data lines used by the PS2 receive interface. It performs the request-to-send sequence, shifts out the frame on device-generated clocks, and checks the device ACK. Outputs are open-drain enables; the top level builds the tri-state inouts, e.g. ps2_clock = ps2_clk_oe ? 1'b0 : 1'bz.

Parameters:
INHIBIT_CYCLES, 6000, clock cycles ps2_clk_oe is held low before the start bit (120 us at 50 MHz; must be at least 100 us).
TIMEOUT_CYCLES, 1000000, watchdog limit from clock release to ACK-phase completion (20 ms at 50 MHz).

Ports:
clock  input  1  system clock (CLOCK_50 domain)
resetn  input  1  asynchronous active-low reset
send_cmd  input  1  1-cycle request; sampled only in IDLE
command  input  8  byte to send; latched when send_cmd is accepted
ps2_clk_in  input  1  raw ps2_clock pin value (asynchronous)
ps2_data_in  input  1  raw ps2_data pin value (asynchronous)
ps2_clk_oe  output  1  1 = drive ps2_clock low
ps2_data_oe  output  1  1 = drive ps2_data low
busy  output  1  high from the cycle after acceptance until return to IDLE
cmd_sent  output  1  1-cycle pulse on an ACKed transfer
error  output  1  1-cycle pulse on NACK or timeout

Behaviour:
- Reset (asynchronous, resetn=0): state IDLE; all outputs 0; counters, shift register and synchronizers cleared (synchronizers set to 1, which is the idle line level).
- Input sync: 2-flop synchronizer on each pin, plus one history flop on the clock. clk_fall = hist & ~sync_clk. Edge detection therefore lags the pin by 2-3 cycles.
- Frame shift register (10 bits, LSB first) = {stop=1, parity=~^command, command[7:0]}.
- IDLE: oe outputs 0. On send_cmd=1, latch the frame, clear the counter and go to INHIBIT. ps2_clk_oe=1 and busy=1 on the next cycle.
- INHIBIT: ps2_clk_oe=1 for exactly INHIBIT_CYCLES cycles. On the last cycle go to REQ.
- REQ (1 cycle): ps2_data_oe=1 (start bit) with ps2_clk_oe still 1. Next state is SEND: ps2_clk_oe=0, bit_cnt=0, watchdog cleared.
- SEND: on each clk_fall, set ps2_data_oe = ~shift[0], shift right and increment bit_cnt.
  - Falling edges 1..8 present data bits 0..7, edge 9 presents parity, edge 10 presents stop (data released).
  - After edge 10, go to ACK.
- ACK: on the next clk_fall (edge 11), sample sync_data. If 0 go to WAIT_IDLE. If 1 go to FAIL.
- WAIT_IDLE: wait until sync_clk=1 and sync_data=1 in the same cycle, then go to DONE.
- DONE (1 cycle): cmd_sent=1, then IDLE. busy drops in the IDLE cycle.
- FAIL (1 cycle): both oe=0, error=1, then IDLE.
- Watchdog: counts every cycle in SEND, ACK and WAIT_IDLE. On reaching TIMEOUT_CYCLES, go to FAIL and release both lines within 1 cycle.
- send_cmd while busy is ignored; no queueing. command changes after acceptance have no effect.
- Both oe outputs are never 1 in IDLE, DONE or FAIL. ps2_clk_oe is 1 only in INHIBIT and REQ.
- Reset mid-transfer releases both lines immediately (asynchronous). No pulse is emitted.
- Receive-side bytes that arrive during a transfer are the receiver's responsibility; this block ignores them.

Test Plan:
1. send_cmd with command=0xED and a device model clocking at 12.5 kHz, ACK low on edge 11. Required: ps2_clk_oe high for exactly 6000 cycles, start bit low, data bits 1,0,1,1,0,1,1,1, parity 1, stop released. Then one cmd_sent pulse, error=0, busy low afterwards.
2. command=0xF4 (5 ones). Required: parity bit 0 (ps2_data_oe=1 during edge-9 phase), transfer completes with cmd_sent.
3. NACK: device leaves data high on edge 11. Required: error pulses once, cmd_sent stays 0, both oe=0, busy falls.
4. Timeout: no device clock after REQ. Required: error after exactly TIMEOUT_CYCLES cycles in SEND, lines released, back to IDLE. A subsequent 0xFF transfer succeeds.
5. Second send_cmd with 0x00 issued mid-transfer of 0xED. Required: ignored; the wire shows only 0xED and a single cmd_sent.
6. resetn asserted after edge 5. Required: ps2_clk_oe=ps2_data_oe=busy=0 asynchronously, no cmd_sent/error. After release, a fresh transfer completes normally.

Source files
------------

// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module      : ps2_host_tx
// Description : PS/2 host-to-device command transmitter. Sends one byte to the
//               keyboard using the request-to-send sequence. It shifts the
//               frame out on device-generated clock edges and checks the
//               device ACK. The pin outputs are open-drain enables (1 = pull
//               low). The parent module builds the tri-state pads.
// Ports       : clock        system clock
//               resetn       asynchronous active-low reset
//               send_cmd     1-cycle request, sampled only when idle
//               command      byte to send, latched on acceptance
//               ps2_clk_in   raw ps2_clock pin (asynchronous)
//               ps2_data_in  raw ps2_data pin (asynchronous)
//               ps2_clk_oe   1 = drive ps2_clock low
//               ps2_data_oe  1 = drive ps2_data low
//               busy         transfer in progress
//               cmd_sent     1-cycle pulse on an ACKed transfer
//               error        1-cycle pulse on NACK or watchdog timeout
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       send_cmd,
  input  logic [7:0] command,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       cmd_sent,
  output logic       error
);

  localparam int IW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [IW-1:0] c_inh_last = IW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] c_wd_last  = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_INHIBIT   = 3'd1,
    S_REQ       = 3'd2,
    S_SEND      = 3'd3,
    S_ACK       = 3'd4,
    S_WAIT_IDLE = 3'd5,
    S_DONE      = 3'd6,
    S_FAIL      = 3'd7
  } state_t;

  state_t          r_state;
  logic [9:0]      r_shift;
  logic [3:0]      r_bit_cnt;
  logic [IW-1:0]   r_inh_cnt;
  logic [TW-1:0]   r_wd_cnt;
  logic            r_clk_oe;
  logic            r_data_oe;
  logic            r_busy;
  logic            r_cmd_sent;
  logic            r_error;

  // Pin synchronizers. They reset to 1 because that is the idle line level.
  logic r_clk_s1, r_clk_s2, r_clk_hist;
  logic r_dat_s1, r_dat_s2;
  logic w_clk_fall;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_clk_s1   <= 1'b1;
      r_clk_s2   <= 1'b1;
      r_clk_hist <= 1'b1;
      r_dat_s1   <= 1'b1;
      r_dat_s2   <= 1'b1;
    end else begin
      r_clk_s1   <= ps2_clk_in;
      r_clk_s2   <= r_clk_s1;
      r_clk_hist <= r_clk_s2;
      r_dat_s1   <= ps2_data_in;
      r_dat_s2   <= r_dat_s1;
    end
  end

  assign w_clk_fall = r_clk_hist & ~r_clk_s2;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state    <= S_IDLE;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_inh_cnt  <= '0;
      r_wd_cnt   <= '0;
      r_clk_oe   <= 1'b0;
      r_data_oe  <= 1'b0;
      r_busy     <= 1'b0;
      r_cmd_sent <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      // Status outputs are single-cycle pulses unless re-asserted below.
      r_cmd_sent <= 1'b0;
      r_error    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_clk_oe  <= 1'b0;
          r_data_oe <= 1'b0;
          r_busy    <= 1'b0;
          if (send_cmd) begin
            // Frame sent LSB first: data bits, odd parity, stop bit.
            r_shift   <= {1'b1, ~^command, command};
            r_inh_cnt <= '0;
            r_clk_oe  <= 1'b1;
            r_busy    <= 1'b1;
            r_state   <= S_INHIBIT;
          end
        end
        S_INHIBIT: begin
          if (r_inh_cnt == c_inh_last) begin
            r_data_oe <= 1'b1;  // start bit, clock still held low
            r_state   <= S_REQ;
          end else begin
            r_inh_cnt <= r_inh_cnt + 1'b1;
          end
        end
        S_REQ: begin
          // Release the clock. The start bit stays driven until the device
          // clocks it in.
          r_clk_oe  <= 1'b0;
          r_bit_cnt <= '0;
          r_wd_cnt  <= '0;
          r_state   <= S_SEND;
        end
        S_SEND, S_ACK, S_WAIT_IDLE: begin
          if (r_wd_cnt == c_wd_last) begin
            // The device stopped responding. Let go of both lines.
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
            r_error   <= 1'b1;
            r_state   <= S_FAIL;
          end else begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
            if (r_state == S_SEND) begin
              if (w_clk_fall) begin
                r_data_oe <= ~r_shift[0];
                r_shift   <= {1'b0, r_shift[9:1]};
                r_bit_cnt <= r_bit_cnt + 1'b1;
                if (r_bit_cnt == 4'd9) begin
                  r_state <= S_ACK;
                end
              end
            end else if (r_state == S_ACK) begin
              if (w_clk_fall) begin
                if (!r_dat_s2) begin
                  r_state <= S_WAIT_IDLE;
                end else begin
                  r_data_oe <= 1'b0;
                  r_error   <= 1'b1;
                  r_state   <= S_FAIL;
                end
              end
            end else begin
              // The device must release both lines before the bus is
              // considered free again.
              if (r_clk_s2 && r_dat_s2) begin
                r_cmd_sent <= 1'b1;
                r_state    <= S_DONE;
              end
            end
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        S_FAIL: begin
          r_clk_oe  <= 1'b0;
          r_data_oe <= 1'b0;
          r_busy    <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: begin
          r_clk_oe  <= 1'b0;
          r_data_oe <= 1'b0;
          r_busy    <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  assign ps2_clk_oe  = r_clk_oe;
  assign ps2_data_oe = r_data_oe;
  assign busy        = r_busy;
  assign cmd_sent    = r_cmd_sent;
  assign error       = r_error;

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_host_tx
// Description : Testbench for ps2_host_tx. It includes a behavioural keyboard
//               model on wired-AND lines. Stimulus pushes the expected
//               outcome for each transfer. A monitor pops an entry on every
//               cmd_sent/error pulse and compares the outcome, the frame seen
//               on the wire and the line timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_host_tx;

  localparam int INH = 60;
  localparam int TO  = 2000;

  localparam int K_ACK  = 0;
  localparam int K_NACK = 1;
  localparam int K_TOUT = 2;

  logic       clk;
  logic       resetn;
  logic       send_cmd;
  logic [7:0] command;
  logic       ps2_clk_in;
  logic       ps2_data_in;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       busy;
  logic       cmd_sent;
  logic       error;

  logic       dev_clk;
  logic       dev_data;
  logic [10:0] dev_frame;
  int         half;

  int n_checks;
  int n_fail;

  typedef struct {
    logic [7:0] cmd;
    int         kind;
  } exp_t;

  exp_t exp_q[$];

  int inh_run, req_run, send_run;

  // Open-drain bus: either side can pull a line low.
  assign ps2_clk_in  = dev_clk  & ~ps2_clk_oe;
  assign ps2_data_in = dev_data & ~ps2_data_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock      (clk),
    .resetn     (resetn),
    .send_cmd   (send_cmd),
    .command    (command),
    .ps2_clk_in (ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .busy       (busy),
    .cmd_sent   (cmd_sent),
    .error      (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input int act);
    n_checks++;
    n_fail++;
    $display("FAIL %s: observed %0d", name, act);
  endtask

  // Line sequence for a byte: start 0, eight data bits LSB first, odd parity, stop 1.
  function automatic logic [10:0] frame_of(input logic [7:0] c);
    logic [10:0] f;
    f = 11'd0;
    for (int i = 0; i < 8; i++) f[i+1] = c[i];
    f[9]  = ($countones(c) % 2 == 0) ? 1'b1 : 1'b0;
    f[10] = 1'b1;
    return f;
  endfunction

  // Keyboard model. It waits for the host to release the clock while holding
  // data low. It then generates falling edges and samples the line late in
  // each low phase. For an ACK it pulls data low before edge 11.
  task automatic device_xfer(input int kind, input int nedges);
    int t;
    t = 0;
    dev_frame = 11'h7FF;
    while (!(busy && !ps2_clk_oe && ps2_data_oe)) begin
      @(negedge clk);
      t++;
      if (t > INH + 200) begin
        fail_now("host_release_bound", t);
        return;
      end
    end
    dev_frame[0] = ps2_data_in;
    repeat (half) @(negedge clk);
    for (int k = 1; k <= nedges; k++) begin
      dev_clk = 1'b0;
      repeat (half) @(negedge clk);
      if (k <= 10) dev_frame[k] = ps2_data_in;
      if (k == nedges && nedges < 11) return;
      dev_clk = 1'b1;
      if (k == 10 && kind == K_ACK) dev_data = 1'b0;
      if (k == 11) dev_data = 1'b1;
      repeat (half) @(negedge clk);
    end
  endtask

  task automatic wait_idle(input int limit);
    int t;
    t = 0;
    while (busy) begin
      @(negedge clk);
      t++;
      if (t > limit) begin
        fail_now("busy_drop_bound", t);
        return;
      end
    end
  endtask

  task automatic issue(input logic [7:0] c);
    @(posedge clk);
    #1;
    command  = c;
    send_cmd = 1'b1;
    @(posedge clk);
    #1;
    send_cmd = 1'b0;
    command  = 8'($urandom);  // later changes must not affect the frame
  endtask

  task automatic transfer(input logic [7:0] c, input int kind);
    exp_t e;
    e.cmd  = c;
    e.kind = kind;
    exp_q.push_back(e);
    issue(c);
    if (kind != K_TOUT) device_xfer(kind, 11);
    wait_idle(INH + TO + 1000);
    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
  endtask

  // Monitor: line timing, idle invariants, and outcome scoreboard.
  initial begin
    bit   prev_busy;
    bit   chk_next;
    exp_t e;
    prev_busy = 1'b0;
    chk_next  = 1'b0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        prev_busy = 1'b0;
        chk_next  = 1'b0;
        continue;
      end
      if (chk_next) begin
        chk_next = 1'b0;
        check("pulse_width", {30'd0, cmd_sent, error}, 32'd0);
        check("busy_after_pulse", {31'd0, busy}, 32'd0);
      end
      if (busy && !prev_busy) begin
        inh_run  = 0;
        req_run  = 0;
        send_run = 0;
      end
      prev_busy = busy;
      if (busy && ps2_clk_oe && !ps2_data_oe) inh_run++;
      if (ps2_clk_oe && ps2_data_oe) req_run++;
      if (busy && !ps2_clk_oe && !cmd_sent && !error) send_run++;
      if (!busy) check("lines_idle", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
      if (cmd_sent || error) begin
        chk_next = 1'b1;
        if (exp_q.size() == 0) begin
          fail_now("unexpected_pulse", {cmd_sent, error});
        end else begin
          e = exp_q.pop_front();
          check("outcome", {30'd0, cmd_sent, error}, (e.kind == K_ACK) ? 32'd2 : 32'd1);
          check("lines_released", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
          check("inhibit_len", inh_run, INH);
          check("start_req_len", req_run, 1);
          if (e.kind == K_TOUT) check("timeout_len", send_run, TO);
          else check("wire_frame", {21'd0, dev_frame}, {21'd0, frame_of(e.cmd)});
        end
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL global_time_limit: simulation time %0t", $time);
    $fatal(1, "time limit");
  end

  initial begin
    logic [7:0] c;
    int         kind;
    n_checks = 0;
    n_fail   = 0;
    resetn   = 1'b0;
    send_cmd = 1'b0;
    command  = 8'h00;
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    half     = 20;
    repeat (3) @(negedge clk);
    check("reset_outputs", {27'd0, ps2_clk_oe, ps2_data_oe, busy, cmd_sent, error}, 32'd0);
    resetn = 1'b1;
    repeat (3) @(negedge clk);

    transfer(8'hED, K_ACK);
    transfer(8'hF4, K_ACK);
    transfer(8'($urandom), K_NACK);
    transfer(8'($urandom), K_TOUT);
    transfer(8'hFF, K_ACK);

    // A request during a transfer must be dropped.
    fork
      begin
        repeat (150) @(posedge clk);
        #1;
        send_cmd = 1'b1;
        command  = 8'h00;
        @(posedge clk);
        #1;
        send_cmd = 1'b0;
      end
    join_none
    transfer(8'hED, K_ACK);
    repeat (100) @(negedge clk);
    check("no_extra_transfer", {31'd0, busy}, 32'd0);

    // Reset in the middle of a frame, after edge 5.
    issue(8'hED);
    device_xfer(K_ACK, 5);
    #3;
    resetn = 1'b0;
    #1;
    check("async_reset_release", {27'd0, ps2_clk_oe, ps2_data_oe, busy, cmd_sent, error}, 32'd0);
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (20) @(negedge clk);
    check("post_reset_idle", {31'd0, busy}, 32'd0);
    transfer(8'hED, K_ACK);

    for (int i = 0; i < 6; i++) begin
      c    = 8'($urandom);
      kind = ($urandom_range(0, 3) == 0) ? K_NACK : K_ACK;
      half = $urandom_range(12, 30);
      transfer(c, kind);
    end

    check("final_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
